// File: rtl/ccip_avmm_mc_requestor_if.sv
// Bus bundle for the multi-channel AVMM-to-CCI-P requestor: kernel-side AVMM
// channels plus the CCI-P c0/c1 Tx requests and Rx responses.
interface ccip_avmm_mc_requestor_if #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_WIDTH  = 42,
    parameter int DATA_WIDTH  = 512,
    parameter int MDATA_WIDTH = 16
);
    logic [NUM_CH-1:0]            avmm_read;
    logic [NUM_CH-1:0]            avmm_write;
    logic [NUM_CH*ADDR_WIDTH-1:0] avmm_address;
    logic [NUM_CH*DATA_WIDTH-1:0] avmm_writedata;
    logic [NUM_CH-1:0]            avmm_waitrequest;
    logic [NUM_CH*DATA_WIDTH-1:0] avmm_readdata;
    logic [NUM_CH-1:0]            avmm_readdatavalid;
    logic [NUM_CH-1:0]            avmm_writeresponsevalid;

    logic                         c0TxAlmFull;
    logic                         c1TxAlmFull;
    logic                         c0tx_valid;
    logic [ADDR_WIDTH-1:0]        c0tx_addr;
    logic [MDATA_WIDTH-1:0]       c0tx_mdata;
    logic                         c1tx_valid;
    logic [ADDR_WIDTH-1:0]        c1tx_addr;
    logic [DATA_WIDTH-1:0]        c1tx_data;
    logic [MDATA_WIDTH-1:0]       c1tx_mdata;

    logic                         c0rx_rsp_valid;
    logic [MDATA_WIDTH-1:0]       c0rx_mdata;
    logic [DATA_WIDTH-1:0]        c0rx_data;
    logic                         c1rx_rsp_valid;
    logic [MDATA_WIDTH-1:0]       c1rx_mdata;

    // Requestor block side.
    modport slave (
        input  avmm_read, avmm_write, avmm_address, avmm_writedata,
        output avmm_waitrequest, avmm_readdata, avmm_readdatavalid, avmm_writeresponsevalid,
        input  c0TxAlmFull, c1TxAlmFull,
        output c0tx_valid, c0tx_addr, c0tx_mdata,
        output c1tx_valid, c1tx_addr, c1tx_data, c1tx_mdata,
        input  c0rx_rsp_valid, c0rx_mdata, c0rx_data,
        input  c1rx_rsp_valid, c1rx_mdata
    );

    // Kernel masters plus host CCI-P port, seen from outside the requestor.
    modport master (
        output avmm_read, avmm_write, avmm_address, avmm_writedata,
        input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid, avmm_writeresponsevalid,
        output c0TxAlmFull, c1TxAlmFull,
        input  c0tx_valid, c0tx_addr, c0tx_mdata,
        input  c1tx_valid, c1tx_addr, c1tx_data, c1tx_mdata,
        output c0rx_rsp_valid, c0rx_mdata, c0rx_data,
        output c1rx_rsp_valid, c1rx_mdata
    );
endinterface

// File: rtl/ccip_avmm_mc_requestor.sv
// Multi-channel AVMM requestor: round-robin reads onto c0 Tx and writes onto c1 Tx,
// per-channel reorder buffers return read data in issue order.
module ccip_avmm_mc_requestor #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_WIDTH  = 42,
    parameter int DATA_WIDTH  = 512,
    parameter int RD_DEPTH    = 8,
    parameter int MDATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ccip_avmm_mc_requestor_if.slave bus
);
    localparam int SEQ_W = $clog2(RD_DEPTH);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RDC_W = SEQ_W + 1;
    localparam int WRC_W = $clog2(RD_DEPTH * 64) + 1;
    localparam int CHF_W = MDATA_WIDTH - SEQ_W;

    logic [CH_W-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [SEQ_W-1:0]             issue_ptr_q [NUM_CH];
    logic [SEQ_W-1:0]             issue_ptr_d [NUM_CH];
    logic [SEQ_W-1:0]             drain_ptr_q [NUM_CH];
    logic [SEQ_W-1:0]             drain_ptr_d [NUM_CH];
    logic [RDC_W-1:0]             rd_out_q    [NUM_CH];
    logic [RDC_W-1:0]             rd_out_d    [NUM_CH];
    logic [WRC_W-1:0]             wr_out_q    [NUM_CH];
    logic [WRC_W-1:0]             wr_out_d    [NUM_CH];
    logic [RD_DEPTH-1:0]          rob_vld_q   [NUM_CH];
    logic [RD_DEPTH-1:0]          rob_vld_d   [NUM_CH];
    logic [DATA_WIDTH-1:0]        rob_data_q  [NUM_CH][RD_DEPTH];

    logic                         c0tx_valid_q, c0tx_valid_d;
    logic [ADDR_WIDTH-1:0]        c0tx_addr_q, c0tx_addr_d;
    logic [MDATA_WIDTH-1:0]       c0tx_mdata_q, c0tx_mdata_d;
    logic                         c1tx_valid_q, c1tx_valid_d;
    logic [ADDR_WIDTH-1:0]        c1tx_addr_q, c1tx_addr_d;
    logic [DATA_WIDTH-1:0]        c1tx_data_q, c1tx_data_d;
    logic [MDATA_WIDTH-1:0]       c1tx_mdata_q, c1tx_mdata_d;
    logic [NUM_CH*DATA_WIDTH-1:0] readdata_q, readdata_d;
    logic [NUM_CH-1:0]            rdv_q, rdv_d, wrv_q, wrv_d;

    logic [NUM_CH-1:0]            rd_elig, wr_elig, rd_gnt, wr_gnt, drain;
    logic                         rd_found, wr_found;
    logic [CH_W-1:0]              rd_idx, wr_idx;

    logic [CHF_W-1:0]             c0_chf;
    logic [SEQ_W-1:0]             c0_seq;
    logic [CH_W-1:0]              c0_ch;
    logic                         c0_hit;

    // First requesting channel at or after ptr; MSB of the result flags a grant.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   ptr);
        logic [CH_W:0] pick;
        int unsigned   c;
        pick = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            c = 32'(ptr) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!pick[CH_W] && req[CH_W'(c)]) pick = {1'b1, CH_W'(c)};
        end
        return pick;
    endfunction

    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] idx);
        return (32'(idx) == NUM_CH - 1) ? '0 : idx + 1'b1;
    endfunction

    // Gating with reset_n holds waitrequest high while reset is asserted.
    always_comb begin
        rd_elig = '0;
        wr_elig = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rd_elig[i] = reset_n && bus.avmm_read[i] && !bus.c0TxAlmFull
                         && (rd_out_q[i] < RDC_W'(RD_DEPTH));
            wr_elig[i] = reset_n && bus.avmm_write[i] && !bus.avmm_read[i] && !bus.c1TxAlmFull;
        end
    end

    assign {rd_found, rd_idx} = rr_pick(rd_elig, rd_ptr_q);
    assign {wr_found, wr_idx} = rr_pick(wr_elig, wr_ptr_q);
    assign rd_ptr_d = rd_found ? rr_next(rd_idx) : rd_ptr_q;
    assign wr_ptr_d = wr_found ? rr_next(wr_idx) : wr_ptr_q;

    always_comb begin
        rd_gnt = '0;
        wr_gnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rd_gnt[i] = rd_found && (rd_idx == CH_W'(i));
            wr_gnt[i] = wr_found && (wr_idx == CH_W'(i));
        end
    end

    always_comb begin
        c0tx_valid_d = rd_found;
        c0tx_addr_d  = c0tx_addr_q;
        c0tx_mdata_d = c0tx_mdata_q;
        c1tx_valid_d = wr_found;
        c1tx_addr_d  = c1tx_addr_q;
        c1tx_data_d  = c1tx_data_q;
        c1tx_mdata_d = c1tx_mdata_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_gnt[i]) begin
                c0tx_addr_d  = bus.avmm_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                c0tx_mdata_d = MDATA_WIDTH'({CH_W'(i), issue_ptr_q[i]});
            end
            if (wr_gnt[i]) begin
                c1tx_addr_d  = bus.avmm_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                c1tx_data_d  = bus.avmm_writedata[i*DATA_WIDTH +: DATA_WIDTH];
                c1tx_mdata_d = MDATA_WIDTH'({CH_W'(i), {SEQ_W{1'b0}}});
            end
        end
    end

    // The whole field above seq is decoded so stray pad bits never alias onto a real channel.
    assign c0_chf = bus.c0rx_mdata[MDATA_WIDTH-1:SEQ_W];
    assign c0_seq = bus.c0rx_mdata[SEQ_W-1:0];
    assign c0_ch  = CH_W'(c0_chf);
    assign c0_hit = bus.c0rx_rsp_valid && ({1'b0, c0_chf} < (CHF_W + 1)'(NUM_CH));

    always_comb begin
        drain      = '0;
        wrv_d      = '0;
        readdata_d = readdata_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            drain[i]       = rob_vld_q[i][drain_ptr_q[i]];
            issue_ptr_d[i] = issue_ptr_q[i] + SEQ_W'(rd_gnt[i]);
            drain_ptr_d[i] = drain_ptr_q[i] + SEQ_W'(drain[i]);
            if (drain[i])
                readdata_d[i*DATA_WIDTH +: DATA_WIDTH] = rob_data_q[i][drain_ptr_q[i]];

            rob_vld_d[i] = rob_vld_q[i];
            if (drain[i]) rob_vld_d[i][drain_ptr_q[i]] = 1'b0;
            if (c0_hit && (c0_ch == CH_W'(i))) rob_vld_d[i][c0_seq] = 1'b1;

            rd_out_d[i] = rd_out_q[i];
            if (rd_gnt[i] && !drain[i])      rd_out_d[i] = rd_out_q[i] + 1'b1;
            else if (!rd_gnt[i] && drain[i]) rd_out_d[i] = rd_out_q[i] - 1'b1;

            wrv_d[i] = bus.c1rx_rsp_valid && (bus.c1rx_mdata == MDATA_WIDTH'(i << SEQ_W));
            wr_out_d[i] = wr_out_q[i];
            if (wr_gnt[i] && !wrv_d[i])      wr_out_d[i] = wr_out_q[i] + 1'b1;
            else if (!wr_gnt[i] && wrv_d[i]) wr_out_d[i] = wr_out_q[i] - 1'b1;
        end
        rdv_d = drain;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            issue_ptr_q  <= '{default: '0};
            drain_ptr_q  <= '{default: '0};
            rd_out_q     <= '{default: '0};
            wr_out_q     <= '{default: '0};
            rob_vld_q    <= '{default: '0};
            c0tx_valid_q <= 1'b0;
            c0tx_addr_q  <= '0;
            c0tx_mdata_q <= '0;
            c1tx_valid_q <= 1'b0;
            c1tx_addr_q  <= '0;
            c1tx_data_q  <= '0;
            c1tx_mdata_q <= '0;
            readdata_q   <= '0;
            rdv_q        <= '0;
            wrv_q        <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            issue_ptr_q  <= issue_ptr_d;
            drain_ptr_q  <= drain_ptr_d;
            rd_out_q     <= rd_out_d;
            wr_out_q     <= wr_out_d;
            rob_vld_q    <= rob_vld_d;
            c0tx_valid_q <= c0tx_valid_d;
            c0tx_addr_q  <= c0tx_addr_d;
            c0tx_mdata_q <= c0tx_mdata_d;
            c1tx_valid_q <= c1tx_valid_d;
            c1tx_addr_q  <= c1tx_addr_d;
            c1tx_data_q  <= c1tx_data_d;
            c1tx_mdata_q <= c1tx_mdata_d;
            readdata_q   <= readdata_d;
            rdv_q        <= rdv_d;
            wrv_q        <= wrv_d;
        end
    end

    // Line storage carries no reset; slot-valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (c0_hit) rob_data_q[c0_ch][c0_seq] <= bus.c0rx_data;
    end

    assign bus.avmm_waitrequest        = ~(rd_gnt | wr_gnt);
    assign bus.avmm_readdata           = readdata_q;
    assign bus.avmm_readdatavalid      = rdv_q;
    assign bus.avmm_writeresponsevalid = wrv_q;
    assign bus.c0tx_valid              = c0tx_valid_q;
    assign bus.c0tx_addr               = c0tx_addr_q;
    assign bus.c0tx_mdata              = c0tx_mdata_q;
    assign bus.c1tx_valid              = c1tx_valid_q;
    assign bus.c1tx_addr               = c1tx_addr_q;
    assign bus.c1tx_data               = c1tx_data_q;
    assign bus.c1tx_mdata              = c1tx_mdata_q;
endmodule

// File: tb/tb_ccip_avmm_mc_requestor.sv
// Directed bench for ccip_avmm_mc_requestor: tag format, arbitration rotation,
// ROB reordering, outstanding-read stall, AlmFull back-pressure and reset.
module tb_ccip_avmm_mc_requestor;
    localparam int NUM_CH      = 4;
    localparam int ADDR_WIDTH  = 42;
    localparam int DATA_WIDTH  = 512;
    localparam int RD_DEPTH    = 8;
    localparam int MDATA_WIDTH = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    ccip_avmm_mc_requestor_if #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .MDATA_WIDTH(MDATA_WIDTH)
    ) bus ();

    ccip_avmm_mc_requestor #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .RD_DEPTH(RD_DEPTH), .MDATA_WIDTH(MDATA_WIDTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] mkline(input logic [31:0] s);
        return {16{s}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.avmm_read      = '0;
        bus.avmm_write     = '0;
        bus.avmm_address   = '0;
        bus.avmm_writedata = '0;
        bus.c0TxAlmFull    = 1'b0;
        bus.c1TxAlmFull    = 1'b0;
        bus.c0rx_rsp_valid = 1'b0;
        bus.c0rx_mdata     = '0;
        bus.c0rx_data      = '0;
        bus.c1rx_rsp_valid = 1'b0;
        bus.c1rx_mdata     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        bus.avmm_read  = 4'hF;
        bus.avmm_write = 4'hF;
        step();
        step();
        checks++;
        if (bus.avmm_waitrequest !== 4'hF) begin
            failures++; $display("FAIL reset_waitrequest got=%h exp=f", bus.avmm_waitrequest);
        end
        checks++;
        if (bus.c0tx_valid !== 1'b0 || bus.c1tx_valid !== 1'b0) begin
            failures++; $display("FAIL reset_tx_valid got=%b%b exp=00", bus.c0tx_valid, bus.c1tx_valid);
        end
        checks++;
        if (bus.avmm_readdatavalid !== 4'h0 || bus.avmm_writeresponsevalid !== 4'h0) begin
            failures++; $display("FAIL reset_rsp_valid got=%h/%h exp=0/0",
                                 bus.avmm_readdatavalid, bus.avmm_writeresponsevalid);
        end
        checks++;
        if (bus.c0tx_mdata !== '0 || bus.c1tx_mdata !== '0 || bus.c0tx_addr !== '0
            || bus.c1tx_addr !== '0 || bus.avmm_readdata !== '0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus.c0tx_mdata,
                                 bus.c1tx_mdata, bus.c0tx_addr, bus.c1tx_addr);
        end
        idle_inputs();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        logic [DATA_WIDTH-1:0] d;
        d = mkline(32'h5A5A_0001);
        bus.avmm_address[0 +: ADDR_WIDTH] = 42'h100;
        bus.avmm_read[0] = 1'b1;
        #1;
        checks++;
        if (bus.avmm_waitrequest !== 4'b1110) begin
            failures++; $display("FAIL single_read_wait got=%b exp=1110", bus.avmm_waitrequest);
        end
        step();
        bus.avmm_read[0] = 1'b0;
        checks++;
        if (bus.c0tx_valid !== 1'b1 || bus.c0tx_addr !== 42'h100 || bus.c0tx_mdata !== 16'h0000) begin
            failures++; $display("FAIL single_read_tx got=%b/%h/%h exp=1/100/0000",
                                 bus.c0tx_valid, bus.c0tx_addr, bus.c0tx_mdata);
        end
        step();
        checks++;
        if (bus.c0tx_valid !== 1'b0) begin
            failures++; $display("FAIL single_read_tx_pulse got=%b exp=0", bus.c0tx_valid);
        end
        repeat (4) step();
        bus.c0rx_rsp_valid = 1'b1;
        bus.c0rx_mdata     = 16'h0000;
        bus.c0rx_data      = d;
        step();
        bus.c0rx_rsp_valid = 1'b0;
        checks++;
        if (bus.avmm_readdatavalid !== 4'h0) begin
            failures++; $display("FAIL single_read_early got=%b exp=0000", bus.avmm_readdatavalid);
        end
        step();
        checks++;
        if (bus.avmm_readdatavalid !== 4'b0001 || bus.avmm_readdata[0 +: DATA_WIDTH] !== d) begin
            failures++; $display("FAIL single_read_data got=%b/%h exp=0001/%h",
                                 bus.avmm_readdatavalid, bus.avmm_readdata[0 +: DATA_WIDTH], d);
        end
        step();
        checks++;
        if (bus.avmm_readdatavalid !== 4'h0) begin
            failures++; $display("FAIL single_read_pulse got=%b exp=0000", bus.avmm_readdatavalid);
        end
    endtask

    task automatic test_reorder();
        int order[4] = '{3, 1, 0, 2};
        logic [DATA_WIDTH-1:0] exp_d;
        bus.avmm_read[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus.avmm_address[1*ADDR_WIDTH +: ADDR_WIDTH] = 42'h200 + 42'(n);
            step();
            checks++;
            if (bus.c0tx_valid !== 1'b1 || bus.c0tx_mdata !== 16'(16'h0008 + n)
                || bus.c0tx_addr !== 42'h200 + 42'(n)) begin
                failures++; $display("FAIL reorder_issue n=%0d got=%b/%h/%h exp=1/%h/%h", n,
                                     bus.c0tx_valid, bus.c0tx_mdata, bus.c0tx_addr,
                                     16'(16'h0008 + n), 42'h200 + 42'(n));
            end
        end
        bus.avmm_read[1] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) begin
                bus.c0rx_rsp_valid = 1'b1;
                bus.c0rx_mdata     = 16'(16'h0008 + order[j]);
                bus.c0rx_data      = mkline(32'hA100_0000 + 32'(order[j]));
            end else begin
                bus.c0rx_rsp_valid = 1'b0;
            end
            step();
            exp_d = mkline(32'hA100_0000 + 32'(j - 3));
            checks++;
            if (j >= 3 && j <= 6) begin
                if (bus.avmm_readdatavalid !== 4'b0010
                    || bus.avmm_readdata[1*DATA_WIDTH +: DATA_WIDTH] !== exp_d) begin
                    failures++; $display("FAIL reorder_drain j=%0d got=%b/%h exp=0010/%h", j,
                                         bus.avmm_readdatavalid,
                                         bus.avmm_readdata[1*DATA_WIDTH +: DATA_WIDTH], exp_d);
                end
            end else if (bus.avmm_readdatavalid !== 4'b0000) begin
                failures++; $display("FAIL reorder_idle j=%0d got=%b exp=0000", j, bus.avmm_readdatavalid);
            end
        end
    endtask

    task automatic test_rotation_stall();
        logic [3:0] exp_w;
        logic [DATA_WIDTH-1:0] d;
        do_reset();
        for (int i = 0; i < NUM_CH; i++)
            bus.avmm_address[i*ADDR_WIDTH +: ADDR_WIDTH] = 42'h1000 * 42'(i + 1);
        bus.avmm_read = 4'hF;
        #1;
        for (int n = 0; n < 4 * RD_DEPTH; n++) begin
            exp_w = ~(4'b0001 << (n % 4));
            checks++;
            if (bus.avmm_waitrequest !== exp_w) begin
                failures++; $display("FAIL rotate_wait n=%0d got=%b exp=%b", n, bus.avmm_waitrequest, exp_w);
            end
            step();
            checks++;
            if (bus.c0tx_valid !== 1'b1 || bus.c0tx_mdata !== 16'((n % 4) * 8 + n / 4)) begin
                failures++; $display("FAIL rotate_tx n=%0d got=%b/%h exp=1/%h", n,
                                     bus.c0tx_valid, bus.c0tx_mdata, 16'((n % 4) * 8 + n / 4));
            end
        end
        checks++;
        if (bus.avmm_waitrequest !== 4'hF) begin
            failures++; $display("FAIL stall_wait got=%b exp=1111", bus.avmm_waitrequest);
        end
        step();
        checks++;
        if (bus.c0tx_valid !== 1'b0) begin
            failures++; $display("FAIL stall_tx got=%b exp=0", bus.c0tx_valid);
        end
        d = mkline(32'hB200_0000);
        bus.c0rx_rsp_valid = 1'b1;
        bus.c0rx_mdata     = 16'h0010;
        bus.c0rx_data      = d;
        step();
        bus.c0rx_rsp_valid = 1'b0;
        checks++;
        if (bus.avmm_waitrequest !== 4'hF) begin
            failures++; $display("FAIL stall_hold got=%b exp=1111", bus.avmm_waitrequest);
        end
        step();
        checks++;
        if (bus.avmm_readdatavalid !== 4'b0100 || bus.avmm_readdata[2*DATA_WIDTH +: DATA_WIDTH] !== d) begin
            failures++; $display("FAIL stall_drain got=%b/%h exp=0100/%h", bus.avmm_readdatavalid,
                                 bus.avmm_readdata[2*DATA_WIDTH +: DATA_WIDTH], d);
        end
        checks++;
        if (bus.avmm_waitrequest !== 4'b1011) begin
            failures++; $display("FAIL stall_release got=%b exp=1011", bus.avmm_waitrequest);
        end
        step();
        bus.avmm_read = 4'h0;
        checks++;
        if (bus.c0tx_valid !== 1'b1 || bus.c0tx_mdata !== 16'h0010) begin
            failures++; $display("FAIL stall_wrap got=%b/%h exp=1/0010", bus.c0tx_valid, bus.c0tx_mdata);
        end
    endtask

    task automatic test_almfull();
        int ch;
        do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            bus.avmm_address[i*ADDR_WIDTH +: ADDR_WIDTH]   = 42'h3000 + 42'(i);
            bus.avmm_writedata[i*DATA_WIDTH +: DATA_WIDTH] = mkline(32'hC000_0000 + 32'(i));
        end
        bus.avmm_write[1] = 1'b1;
        #1;
        checks++;
        if (bus.avmm_waitrequest !== 4'b1101) begin
            failures++; $display("FAIL wr_single_wait got=%b exp=1101", bus.avmm_waitrequest);
        end
        step();
        checks++;
        if (bus.c1tx_valid !== 1'b1 || bus.c1tx_mdata !== 16'h0008 || bus.c1tx_addr !== 42'h3001
            || bus.c1tx_data !== mkline(32'hC000_0001)) begin
            failures++; $display("FAIL wr_single_tx got=%b/%h/%h exp=1/0008/3001",
                                 bus.c1tx_valid, bus.c1tx_mdata, bus.c1tx_addr);
        end
        bus.c1TxAlmFull = 1'b1;
        bus.avmm_write  = 4'hF;
        #1;
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (bus.avmm_waitrequest !== 4'hF) begin
                failures++; $display("FAIL almfull_wait n=%0d got=%b exp=1111", n, bus.avmm_waitrequest);
            end
            step();
            checks++;
            if (bus.c1tx_valid !== 1'b0) begin
                failures++; $display("FAIL almfull_tx n=%0d got=%b exp=0", n, bus.c1tx_valid);
            end
        end
        bus.c1TxAlmFull = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            ch = (2 + k) % 4;
            checks++;
            if (bus.avmm_waitrequest !== ~(4'b0001 << ch)) begin
                failures++; $display("FAIL resume_wait k=%0d got=%b exp=%b", k,
                                     bus.avmm_waitrequest, ~(4'b0001 << ch));
            end
            step();
            checks++;
            if (bus.c1tx_valid !== 1'b1 || bus.c1tx_mdata !== 16'(ch * 8)
                || bus.c1tx_data !== mkline(32'hC000_0000 + 32'(ch))) begin
                failures++; $display("FAIL resume_tx k=%0d got=%b/%h exp=1/%h", k,
                                     bus.c1tx_valid, bus.c1tx_mdata, 16'(ch * 8));
            end
        end
        bus.avmm_write = 4'h0;
    endtask

    task automatic test_rw_same_cycle();
        logic [DATA_WIDTH-1:0] d;
        do_reset();
        bus.avmm_address[2*ADDR_WIDTH +: ADDR_WIDTH]   = 42'h4000;
        bus.avmm_writedata[2*DATA_WIDTH +: DATA_WIDTH] = mkline(32'hD2D2_D2D2);
        bus.avmm_read[2]  = 1'b1;
        bus.avmm_write[2] = 1'b1;
        #1;
        checks++;
        if (bus.avmm_waitrequest !== 4'b1011) begin
            failures++; $display("FAIL rw_read_wait got=%b exp=1011", bus.avmm_waitrequest);
        end
        step();
        bus.avmm_read[2] = 1'b0;
        checks++;
        if (bus.c0tx_valid !== 1'b1 || bus.c1tx_valid !== 1'b0 || bus.c0tx_mdata !== 16'h0010) begin
            failures++; $display("FAIL rw_read_first got=%b/%b/%h exp=1/0/0010",
                                 bus.c0tx_valid, bus.c1tx_valid, bus.c0tx_mdata);
        end
        #1;
        checks++;
        if (bus.avmm_waitrequest !== 4'b1011) begin
            failures++; $display("FAIL rw_write_wait got=%b exp=1011", bus.avmm_waitrequest);
        end
        step();
        bus.avmm_write[2] = 1'b0;
        checks++;
        if (bus.c1tx_valid !== 1'b1 || bus.c0tx_valid !== 1'b0 || bus.c1tx_mdata !== 16'h0010
            || bus.c1tx_addr !== 42'h4000 || bus.c1tx_data !== mkline(32'hD2D2_D2D2)) begin
            failures++; $display("FAIL rw_write_next got=%b/%b/%h/%h exp=1/0/0010/4000",
                                 bus.c1tx_valid, bus.c0tx_valid, bus.c1tx_mdata, bus.c1tx_addr);
        end
        bus.c1rx_rsp_valid = 1'b1;
        bus.c1rx_mdata     = 16'h0010;
        step();
        bus.c1rx_rsp_valid = 1'b0;
        checks++;
        if (bus.avmm_writeresponsevalid !== 4'b0100) begin
            failures++; $display("FAIL wr_resp got=%b exp=0100", bus.avmm_writeresponsevalid);
        end
        step();
        checks++;
        if (bus.avmm_writeresponsevalid !== 4'b0000) begin
            failures++; $display("FAIL wr_resp_pulse got=%b exp=0000", bus.avmm_writeresponsevalid);
        end
        // Channel 4 does not exist: both responses must vanish.
        bus.c1rx_rsp_valid = 1'b1;
        bus.c1rx_mdata     = 16'h0020;
        bus.c0rx_rsp_valid = 1'b1;
        bus.c0rx_mdata     = 16'h0020;
        bus.c0rx_data      = mkline(32'hBAD0_BAD0);
        step();
        bus.c1rx_rsp_valid = 1'b0;
        bus.c0rx_rsp_valid = 1'b0;
        checks++;
        if (bus.avmm_writeresponsevalid !== 4'b0000) begin
            failures++; $display("FAIL oob_wr_resp got=%b exp=0000", bus.avmm_writeresponsevalid);
        end
        step();
        checks++;
        if (bus.avmm_readdatavalid !== 4'b0000) begin
            failures++; $display("FAIL oob_rd_resp got=%b exp=0000", bus.avmm_readdatavalid);
        end
        d = mkline(32'hE200_0000);
        bus.c0rx_rsp_valid = 1'b1;
        bus.c0rx_mdata     = 16'h0010;
        bus.c0rx_data      = d;
        step();
        bus.c0rx_rsp_valid = 1'b0;
        step();
        checks++;
        if (bus.avmm_readdatavalid !== 4'b0100 || bus.avmm_readdata[2*DATA_WIDTH +: DATA_WIDTH] !== d) begin
            failures++; $display("FAIL rw_read_data got=%b/%h exp=0100/%h", bus.avmm_readdatavalid,
                                 bus.avmm_readdata[2*DATA_WIDTH +: DATA_WIDTH], d);
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        bus.avmm_address[0 +: ADDR_WIDTH] = 42'h500;
        bus.avmm_read[0] = 1'b1;
        step();
        step();
        step();
        checks++;
        if (bus.c0tx_valid !== 1'b1 || bus.c0tx_mdata !== 16'h0002) begin
            failures++; $display("FAIL midburst_pre got=%b/%h exp=1/0002", bus.c0tx_valid, bus.c0tx_mdata);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.c0tx_valid !== 1'b0 || bus.c0tx_mdata !== 16'h0000 || bus.c0tx_addr !== '0) begin
            failures++; $display("FAIL midburst_async got=%b/%h/%h exp=0/0000/0",
                                 bus.c0tx_valid, bus.c0tx_mdata, bus.c0tx_addr);
        end
        checks++;
        if (bus.avmm_waitrequest !== 4'hF) begin
            failures++; $display("FAIL midburst_wait got=%b exp=1111", bus.avmm_waitrequest);
        end
        step();
        step();
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.avmm_waitrequest !== 4'b1110) begin
            failures++; $display("FAIL post_reset_wait got=%b exp=1110", bus.avmm_waitrequest);
        end
        step();
        bus.avmm_read[0] = 1'b0;
        checks++;
        if (bus.c0tx_valid !== 1'b1 || bus.c0tx_mdata !== 16'h0000 || bus.c0tx_addr !== 42'h500) begin
            failures++; $display("FAIL post_reset_seq got=%b/%h/%h exp=1/0000/500",
                                 bus.c0tx_valid, bus.c0tx_mdata, bus.c0tx_addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_reorder();
        test_rotation_stall();
        test_almfull();
        test_rw_same_cycle();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
